// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds opcode constants, FSM state encodings, ALU operation class codes,
// ALU operand-B and PC source select codes, and the packed control-word
// type produced by the output decoder. The ALU control decoder and the
// datapath import the same constants so that encodings never drift apart.
package multicycle_control_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  // FSM state encodings; 13-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_DONE    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_IMM_EXEC  = 4'd11,
    ST_IMM_DONE  = 4'd12
  } state_t;

  // ALU operation class sent to the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // ALU operand-B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_J, OP_ADDI, OP_ANDI: is_legal_op = 1'b1;
      default:                is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_outputs.sv
// Combinational control-word decoder for the multi-cycle control FSM.
// Ports:
//   state_i     - current FSM state
//   opcode_i    - IR[31:26]
//   mem_ready_i - memory completes the current access this cycle
//   ctrl_o      - full control word; every field not driven by a state is 0
// Only FETCH (ir_write/pc_write follow mem_ready) and DECODE/BRANCH/IMM_EXEC
// (opcode-dependent fields) look at anything other than the state.
module multicycle_control_outputs
  import multicycle_control_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.i_or_d    = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC load only on the cycle the fetch actually completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        // Branch target precompute: PC + (imm << 2)
        ctrl_o.alu_src_a  = 1'b0;
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = ~is_legal_op(opcode_i);
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
      end
      ST_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_RTYPE;
      end
      ST_R_DONE: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = (opcode_i == OP_BNE);
      end
      ST_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      ST_IMM_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      ST_IMM_DONE: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Ports:
//   clk_i, rst_ni      - clock (rising edge) and async active-low reset
//   opcode_i           - IR[31:26], stable from end of FETCH to next FETCH
//   mem_ready_i        - memory completes the current access this cycle
//   pc_write_o .. pc_source_o - datapath control strobes and selects
//   illegal_op_o       - one-cycle pulse on an unsupported opcode in DECODE
//   state_o            - current state, for debug
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | held in reset; leaves on first clock after release
// FETCH     | read instruction at PC, PC+4; waits on mem_ready
// DECODE    | register read, branch target precompute
// MEM_ADDR  | base + offset for lw/sw
// MEM_READ  | data read at ALUOut; waits on mem_ready
// MEM_WB    | MDR -> rt
// MEM_WRITE | data write at ALUOut; waits on mem_ready
// EXECUTE   | R-type ALU op
// R_DONE    | ALUOut -> rd
// BRANCH    | A - B compare, conditional PC load
// JUMP      | PC <- jump target
// IMM_EXEC  | addi/andi ALU op
// IMM_DONE  | ALUOut -> rt
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            pc_write_cond_o,
  output logic            branch_ne_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            mem_to_reg_o,
  output logic            reg_dst_o,
  output logic            reg_write_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic [1:0]      pc_source_o,
  output logic            illegal_op_o,
  output logic [ST_W-1:0] state_o
);

  state_t     state_q, state_d;
  logic [5:0] op;
  ctrl_t      ctrl;

  assign op = opcode_i[5:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
          OP_RTYPE:         state_d = ST_EXECUTE;
          OP_BEQ, OP_BNE:   state_d = ST_BRANCH;
          OP_J:             state_d = ST_JUMP;
          OP_ADDI, OP_ANDI: state_d = ST_IMM_EXEC;
          default:          state_d = ST_FETCH;
        endcase
      end
      // Opcode is held stable, so anything reaching MEM_ADDR is lw or sw
      ST_MEM_ADDR:  state_d = (op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  state_d = mem_ready_i ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: state_d = mem_ready_i ? ST_FETCH : ST_MEM_WRITE;
      ST_EXECUTE:   state_d = ST_R_DONE;
      ST_R_DONE:    state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_IMM_EXEC:  state_d = ST_IMM_DONE;
      ST_IMM_DONE:  state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  multicycle_control_outputs u_outputs (
    .state_i     (state_q),
    .opcode_i    (op),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl)
  );

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign branch_ne_o     = ctrl.branch_ne;
  assign i_or_d_o        = ctrl.i_or_d;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign ir_write_o      = ctrl.ir_write;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_dst_o       = ctrl.reg_dst;
  assign reg_write_o     = ctrl.reg_write;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign alu_op_o        = ctrl.alu_op;
  assign pc_source_o     = ctrl.pc_source;
  assign illegal_op_o    = ctrl.illegal_op;
  assign state_o         = ST_W'(state_q);

endmodule
